// File: rtl/axi4_burst_dma_if.sv
// AXI4 read/write channel bundle between the burst DMA initiator and a responder.
// The master modport is the initiator side; the slave modport is the memory side.
interface axi4_burst_dma_if;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;

    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi4_burst_dma.sv
// Single-command AXI4 copy engine: one INCR read burst into a register buffer,
// then one INCR write burst of the same length, with per-command error status.
module axi4_burst_dma #(
    parameter logic [3:0] AXI_ID    = 4'd1,
    parameter int         MAX_BEATS = 16
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_src,
    input  logic [31:0] cmd_dst,
    input  logic [3:0]  cmd_len,
    output logic        done,
    output logic        err,
    axi4_burst_dma_if.master bus
);
    localparam int DATA_W = 64;

    typedef enum logic [2:0] {IDLE, AR, R, AW, W, B, DONE} state_t;

    state_t            state;
    logic [31:0]       dst_q;
    logic [3:0]        len_q;
    logic [3:0]        cnt;
    logic [DATA_W-1:0] mem_q [MAX_BEATS];

    logic [9:0] src_end;
    logic [9:0] dst_end;
    logic       cmd_bad;
    logic [3:0] cnt_nxt;
    logic       r_bad;
    logic       r_end;
    logic       b_bad;

    // A burst may not cross a 4KB page: the beat index within the page must stay <= 511.
    assign src_end = {1'b0, cmd_src[11:3]} + {6'd0, cmd_len};
    assign dst_end = {1'b0, cmd_dst[11:3]} + {6'd0, cmd_len};
    assign cmd_bad = (|cmd_src[2:0]) | (|cmd_dst[2:0]) | src_end[9] | dst_end[9];

    assign cnt_nxt = cnt + 4'd1;
    assign r_bad   = (bus.rresp != 2'b00) | (bus.rid != AXI_ID) |
                     (bus.rlast && (cnt != len_q)) | (!bus.rlast && (cnt == len_q));
    assign r_end   = bus.rlast | (cnt == len_q);
    assign b_bad   = (bus.bresp != 2'b00) | (bus.bid != AXI_ID);

    assign bus.arid    = AXI_ID;
    assign bus.awid    = AXI_ID;
    assign bus.arsize  = 3'b011;
    assign bus.awsize  = 3'b011;
    assign bus.arburst = 2'b01;
    assign bus.awburst = 2'b01;
    assign bus.wstrb   = 8'hFF;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cmd_ready   <= 1'b1;
            done        <= 1'b0;
            err         <= 1'b0;
            bus.arvalid <= 1'b0;
            bus.araddr  <= 32'd0;
            bus.arlen   <= 8'd0;
            bus.rready  <= 1'b0;
            bus.awvalid <= 1'b0;
            bus.awaddr  <= 32'd0;
            bus.awlen   <= 8'd0;
            bus.wvalid  <= 1'b0;
            bus.wdata   <= '0;
            bus.wlast   <= 1'b0;
            bus.bready  <= 1'b0;
            dst_q       <= 32'd0;
            len_q       <= 4'd0;
            cnt         <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        dst_q     <= cmd_dst;
                        len_q     <= cmd_len;
                        cnt       <= 4'd0;
                        cmd_ready <= 1'b0;
                        if (cmd_bad) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            err         <= 1'b0;
                            bus.arvalid <= 1'b1;
                            bus.araddr  <= cmd_src;
                            bus.arlen   <= {4'b0, cmd_len};
                            state       <= AR;
                        end
                    end
                end
                AR: begin
                    if (bus.arready) begin
                        bus.arvalid <= 1'b0;
                        bus.rready  <= 1'b1;
                        state       <= R;
                    end
                end
                R: begin
                    if (bus.rvalid) begin
                        cnt <= cnt_nxt;
                        if (r_bad) err <= 1'b1;
                        if (r_end) begin
                            bus.rready <= 1'b0;
                            cnt        <= 4'd0;
                            // A failed read never reaches the write side.
                            if (err || r_bad) begin
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                bus.awvalid <= 1'b1;
                                bus.awaddr  <= dst_q;
                                bus.awlen   <= {4'b0, len_q};
                                state       <= AW;
                            end
                        end
                    end
                end
                AW: begin
                    if (bus.awready) begin
                        bus.awvalid <= 1'b0;
                        bus.wvalid  <= 1'b1;
                        bus.wdata   <= mem_q[0];
                        bus.wlast   <= (len_q == 4'd0);
                        cnt         <= 4'd0;
                        state       <= W;
                    end
                end
                W: begin
                    if (bus.wready) begin
                        if (bus.wlast) begin
                            bus.wvalid <= 1'b0;
                            bus.wlast  <= 1'b0;
                            bus.bready <= 1'b1;
                            state      <= B;
                        end else begin
                            cnt       <= cnt_nxt;
                            bus.wdata <= mem_q[cnt_nxt];
                            bus.wlast <= (cnt_nxt == len_q);
                        end
                    end
                end
                B: begin
                    if (bus.bvalid) begin
                        if (b_bad) err <= 1'b1;
                        bus.bready <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Beat buffer holds data only; it is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (state == R && bus.rvalid && bus.rready) mem_q[cnt] <= bus.rdata;
    end
endmodule

// File: tb/tb_axi4_burst_dma.sv
// Bench for axi4_burst_dma: vector table of copy commands against a modelled
// AXI4 responder, with a scoreboard matching read beats to write beats.
module tb_axi4_burst_dma;
    localparam logic [3:0] AXI_ID = 4'd1;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_src;
    logic [31:0] cmd_dst;
    logic [3:0]  cmd_len;
    logic        done;
    logic        err;

    axi4_burst_dma_if bus();

    axi4_burst_dma #(.AXI_ID(AXI_ID), .MAX_BEATS(16)) dut (
        .clock(clock), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
        .done(done), .err(err), .bus(bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [3:0]  len;
        int          rerr_beat;
        bit          rid_bad;
        bit          bresp_bad;
        bit          exp_err;
        int          exp_lat;
        bit          exp_ar;
        bit          exp_aw;
    } vec_t;

    vec_t vecs [12];

    // Responder model state
    bit          stall = 0, hold_w = 0, chk_en = 1;
    int          r_left = 0, r_idx = 0, w_cnt = 0, ar_cnt = 0, aw_cnt = 0;
    bit          r_gap = 0, b_gap = 0, b_pend = 0;
    logic [31:0] r_base = 0, exp_src = 0, exp_dst = 0;
    logic [3:0]  exp_len = 0;
    int          inj_rerr = -1;
    bit          inj_rid = 0, inj_bresp = 0;
    logic [63:0] sb_q [$];

    logic        s_arv = 0, s_arr = 0, s_awv = 0, s_awr = 0, s_wv = 0, s_wr = 0;
    logic        s_rv = 0, s_rr = 0, s_bv = 0, s_br = 0, s_wlast = 0;
    logic [31:0] s_araddr = 0, s_awaddr = 0;
    logic [7:0]  s_arlen = 0, s_awlen = 0;
    logic [63:0] s_wdata = 0, s_rdata = 0;

    function automatic logic [63:0] pat(input logic [31:0] a, input int i);
        logic [7:0] b;
        b = 8'(8'h11 * (i + 1));
        return {a + 32'(i * 8), {4{b}}};
    endfunction

    // Inputs change on the falling edge; handshakes are snapshotted just before the rising edge.
    initial begin
        bus.arready = 0; bus.awready = 0; bus.wready = 0;
        bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0; bus.rid = 0; bus.rlast = 0;
        bus.bvalid = 0; bus.bresp = 0; bus.bid = 0;
        forever begin
            @(negedge clock);
            if (rst_n) begin
                if (s_arv && s_arr) begin
                    ar_cnt++;
                    chk("araddr", s_araddr, exp_src);
                    chk("arlen", s_arlen, {4'b0, exp_len});
                    r_left = int'(s_arlen) + 1; r_idx = 0; r_gap = 1; r_base = s_araddr;
                end
                if (s_rv && s_rr) begin
                    sb_q.push_back(s_rdata);
                    r_idx++; r_left--;
                end
                if (s_awv && s_awr) begin
                    aw_cnt++;
                    chk("awaddr", s_awaddr, exp_dst);
                    chk("awlen", s_awlen, {4'b0, exp_len});
                end
                if (s_wv && s_wr) begin
                    if (sb_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL wbeat_unexpected: got beat %0d expected none", w_cnt);
                    end else begin
                        chk("wdata", s_wdata, sb_q.pop_front());
                        chk("wlast", s_wlast, (w_cnt == int'(exp_len)));
                    end
                    w_cnt++;
                    if (s_wlast) b_gap = 1;
                end
                if (s_bv && s_br) b_pend = 0;
                if (chk_en) begin
                    if (s_arv && !s_arr) chk("ar_hold", {bus.arvalid, bus.arlen, bus.araddr}, {1'b1, s_arlen, s_araddr});
                    if (s_awv && !s_awr) chk("aw_hold", {bus.awvalid, bus.awlen, bus.awaddr}, {1'b1, s_awlen, s_awaddr});
                    if (s_wv && !s_wr) begin
                        chk("w_hold_data", bus.wdata, s_wdata);
                        chk("w_hold_ctl", {bus.wvalid, bus.wlast}, {1'b1, s_wlast});
                    end
                end
            end
            bus.arready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.wready  = hold_w ? 1'b0 : (stall ? 1'($urandom_range(0, 1)) : 1'b1);
            if (r_gap) begin
                r_gap = 0; bus.rvalid = 0; bus.rlast = 0;
            end else if (r_left > 0) begin
                if (!(s_rv && !s_rr)) bus.rvalid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.rdata = pat(r_base, r_idx);
                bus.rlast = (r_left == 1);
                bus.rresp = (r_idx == inj_rerr) ? 2'b10 : 2'b00;
                bus.rid   = (inj_rid && r_idx == 0) ? 4'h5 : AXI_ID;
            end else begin
                bus.rvalid = 0; bus.rlast = 0;
            end
            if (b_gap) begin
                b_gap = 0; b_pend = 1; bus.bvalid = 0;
            end else begin
                bus.bvalid = b_pend;
            end
            bus.bresp = inj_bresp ? 2'b11 : 2'b00;
            bus.bid   = AXI_ID;
            #4;
            s_arv = bus.arvalid; s_arr = bus.arready; s_araddr = bus.araddr; s_arlen = bus.arlen;
            s_awv = bus.awvalid; s_awr = bus.awready; s_awaddr = bus.awaddr; s_awlen = bus.awlen;
            s_wv = bus.wvalid; s_wr = bus.wready; s_wdata = bus.wdata; s_wlast = bus.wlast;
            s_rv = bus.rvalid; s_rr = bus.rready; s_rdata = bus.rdata;
            s_bv = bus.bvalid; s_br = bus.bready;
        end
    end

    task automatic set_vec(input vec_t v);
        exp_src = v.src; exp_dst = v.dst; exp_len = v.len;
        inj_rerr = v.rerr_beat; inj_rid = v.rid_bad; inj_bresp = v.bresp_bad;
        sb_q.delete();
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
    endtask

    task automatic start_cmd(input vec_t v);
        int n;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clock); #1; n++;
        end
        chk("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_src = v.src; cmd_dst = v.dst; cmd_len = v.len; cmd_valid = 1'b1;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        chk("cmd_ready_busy", cmd_ready, 1'b0);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int cyc;
        bit got;
        set_vec(v);
        start_cmd(v);
        cyc = 0; got = 0;
        while (!got && cyc < 300) begin
            @(negedge clock); #1; cyc++;
            if (done) got = 1;
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL %s_timeout: got no done after %0d cycles expected done", tag, cyc);
            return;
        end
        if (v.exp_lat >= 0) chk({tag, "_latency"}, cyc, v.exp_lat);
        chk({tag, "_err"}, err, v.exp_err);
        chk({tag, "_ar_count"}, ar_cnt, v.exp_ar ? 1 : 0);
        chk({tag, "_aw_count"}, aw_cnt, v.exp_aw ? 1 : 0);
        if (v.exp_aw) begin
            chk({tag, "_w_beats"}, w_cnt, int'(v.len) + 1);
            chk({tag, "_sb_empty"}, sb_q.size(), 0);
        end
        @(negedge clock); #1;
        chk({tag, "_done_pulse"}, done, 1'b0);
        chk({tag, "_err_held"}, err, v.exp_err);
        chk({tag, "_ready_after"}, cmd_ready, 1'b1);
    endtask

    initial begin
        vec_t rv;
        int n;
        cmd_valid = 0; cmd_src = 0; cmd_dst = 0; cmd_len = 0;

        vecs[0]  = '{32'h8000_0000, 32'h8000_1000, 4'd3,  -1, 1'b0, 1'b0, 1'b0, 14, 1'b1, 1'b1};
        vecs[1]  = '{32'h8000_0100, 32'h8000_2000, 4'd0,  -1, 1'b0, 1'b0, 1'b0,  8, 1'b1, 1'b1};
        vecs[2]  = '{32'h8000_0000, 32'h8000_0F88, 4'd15, -1, 1'b0, 1'b0, 1'b1,  1, 1'b0, 1'b0};
        vecs[3]  = '{32'h8000_0004, 32'h8000_1000, 4'd15, -1, 1'b0, 1'b0, 1'b1,  1, 1'b0, 1'b0};
        vecs[4]  = '{32'h8000_0000, 32'h8000_1000, 4'd3,   2, 1'b0, 1'b0, 1'b1,  7, 1'b1, 1'b0};
        vecs[5]  = '{32'h8000_0200, 32'h8000_1200, 4'd1,  -1, 1'b0, 1'b0, 1'b0, 10, 1'b1, 1'b1};
        vecs[6]  = '{32'h8000_0300, 32'h8000_1300, 4'd2,  -1, 1'b0, 1'b1, 1'b1, 12, 1'b1, 1'b1};
        vecs[7]  = '{32'h8000_0400, 32'h8000_1400, 4'd3,  -1, 1'b1, 1'b0, 1'b1,  7, 1'b1, 1'b0};
        vecs[8]  = '{32'h8000_0000, 32'h8000_3000, 4'd15, -1, 1'b0, 1'b0, 1'b0, 38, 1'b1, 1'b1};
        vecs[9]  = '{32'h8000_0F80, 32'h8000_1F80, 4'd15, -1, 1'b0, 1'b0, 1'b0, 38, 1'b1, 1'b1};
        vecs[10] = '{32'h8000_0F88, 32'h8000_4000, 4'd15, -1, 1'b0, 1'b0, 1'b1,  1, 1'b0, 1'b0};
        vecs[11] = '{32'h8000_1000, 32'h8000_1001, 4'd0,  -1, 1'b0, 1'b0, 1'b1,  1, 1'b0, 1'b0};

        repeat (2) @(negedge clock);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_done_err", {done, err}, 2'b00);
        chk("rst_valids", {bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready}, 5'b0);
        chk("rst_addr", {bus.araddr, bus.awaddr}, 64'd0);
        chk("rst_wdata", bus.wdata, 64'd0);
        chk("rst_len_last", {bus.arlen, bus.awlen, bus.wlast}, 17'd0);
        chk("rst_size_burst", {bus.arsize, bus.awsize, bus.arburst, bus.awburst}, {3'b011, 3'b011, 2'b01, 2'b01});
        chk("rst_id_strb", {bus.arid, bus.awid, bus.wstrb}, {AXI_ID, AXI_ID, 8'hFF});
        #2 rst_n = 1'b1;

        for (int i = 0; i < 12; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        stall = 1;
        for (int k = 0; k < 3; k++) begin
            rv = vecs[0];
            rv.src = 32'h8000_0000 + 32'(k * 32'h100);
            rv.len = 4'(3 + k * 5);
            rv.exp_lat = -1;
            run_vec($sformatf("stall%0d", k), rv);
        end
        stall = 0;

        rv = vecs[0];
        set_vec(rv);
        start_cmd(rv);
        n = 0;
        while (w_cnt < 1 && n < 100) begin
            @(negedge clock); #1; n++;
        end
        chk("mid_w_reached", w_cnt, 1);
        bus.wready = 1'b0; hold_w = 1;
        @(negedge clock); #1;
        chk("mid_w_pending", bus.wvalid, 1'b1);
        chk_en = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_w_b", {bus.wvalid, bus.bready}, 2'b00);
        chk("mid_rst_cmd_ready", cmd_ready, 1'b1);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_aw_ar", {bus.awvalid, bus.arvalid}, 2'b00);
        hold_w = 0; r_left = 0; r_gap = 0; b_gap = 0; b_pend = 0;
        sb_q.delete();
        repeat (2) @(negedge clock);
        #3 rst_n = 1'b1;
        chk_en = 1;
        rv = vecs[5];
        run_vec("after_rst", rv);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
